// File: rtl/rollback_arbiter.sv
// Recovery-request arbiter: picks the oldest in-range request relative to the ROB head and
// sequences a one-cycle rollback pulse plus drain window. Optional ROLLBACK_ARB_PERF_EN adds counters.
module rollback_arbiter #(
  parameter int unsigned NUM_ROB      = 32,
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DRAIN_CYCLES = 2,
  localparam int unsigned IW          = $clog2(NUM_ROB)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*IW-1:0] req_rob_idx_i,
  input  logic [NUM_REQ*64-1:0] req_target_pc_i,
  input  logic [IW-1:0]        rob_head_i,
  input  logic [IW:0]          rob_count_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 rollback_en_o,
  output logic [IW-1:0]        rollback_idx_o,
  output logic                 redirect_en_o,
  output logic [63:0]          redirect_pc_o,
  output logic                 stall_dispatch_o,
  output logic                 busy_o
`ifdef ROLLBACK_ARB_PERF_EN
  ,
  output logic [31:0]          perf_rollbacks_o,
  output logic [31:0]          perf_preempts_o
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DrainInit = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFire, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   pend_idx_q, pend_idx_d;
  logic [63:0]     pend_pc_q, pend_pc_d;

  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_age;
  logic [IW-1:0]      win_idx;
  logic [63:0]        win_pc;
  logic [IW-1:0]      req_idx;
  logic [IW-1:0]      req_age;
  logic [IW-1:0]      pend_age;
  logic               accept;

  // Oldest in-range request; strict '<' keeps ties on the lowest requester.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    win_age    = '0;
    win_idx    = '0;
    win_pc     = '0;
    req_idx    = '0;
    req_age    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_idx = req_rob_idx_i[i*IW +: IW];
      req_age = req_idx - rob_head_i;
      if (req_valid_i[i] && ({1'b0, req_age} < rob_count_i) &&
          (!win_found || (req_age < win_age))) begin
        win_found     = 1'b1;
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_age       = req_age;
        win_idx       = req_idx;
        win_pc        = req_target_pc_i[i*64 +: 64];
      end
    end
  end

  // Pending age is re-derived every cycle since the head may have advanced.
  always_comb begin
    pend_age = pend_idx_q - rob_head_i;
    accept   = 1'b0;
    if (en_i && win_found) begin
      if (state_q == StIdle) begin
        accept = 1'b1;
      end else begin
        accept = (win_age < pend_age);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_idx_d = pend_idx_q;
    pend_pc_d  = pend_pc_q;
    if (accept) begin
      pend_idx_d = win_idx;
      pend_pc_d  = win_pc;
      state_d    = StFire;
    end else if (en_i) begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StFire: begin
          state_d = StDrain;
          cnt_d   = DrainInit;
        end
        StDrain: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_idx_q <= '0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_idx_q <= pend_idx_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_comb begin
    grant_o          = accept ? win_onehot : '0;
    rollback_en_o    = en_i && (state_q == StFire);
    redirect_en_o    = rollback_en_o;
    rollback_idx_o   = pend_idx_q;
    redirect_pc_o    = pend_pc_q;
    busy_o           = (state_q != StIdle);
    stall_dispatch_o = busy_o;
  end

`ifdef ROLLBACK_ARB_PERF_EN
  logic [31:0] perf_rb_q, perf_rb_d;
  logic [31:0] perf_pre_q, perf_pre_d;

  always_comb begin
    perf_rb_d  = perf_rb_q;
    perf_pre_d = perf_pre_q;
    if (accept && (perf_rb_q != '1)) begin
      perf_rb_d = perf_rb_q + 32'd1;
    end
    if (accept && (state_q != StIdle) && (perf_pre_q != '1)) begin
      perf_pre_d = perf_pre_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rb_q  <= '0;
      perf_pre_q <= '0;
    end else begin
      perf_rb_q  <= perf_rb_d;
      perf_pre_q <= perf_pre_d;
    end
  end

  assign perf_rollbacks_o = perf_rb_q;
  assign perf_preempts_o  = perf_pre_q;
`endif

endmodule

// File: tb/tb_rollback_arbiter.sv
// Bench for rollback_arbiter: table of single-cycle arbitration vectors plus hand-written
// pre-empt / drop / freeze / reset sequences; rollback pulses checked against a scoreboard queue.
module tb_rollback_arbiter;

  logic        clock;
  logic        reset;
  logic        en;
  logic [2:0]  req_valid;
  logic [14:0] req_rob_idx;
  logic [191:0] req_target_pc;
  logic [4:0]  rob_head;
  logic [5:0]  rob_count;
  logic [2:0]  grant;
  logic        rollback_en;
  logic [4:0]  rollback_idx;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        stall_dispatch;
  logic        busy;
`ifdef ROLLBACK_ARB_PERF_EN
  logic [31:0] perf_rollbacks;
  logic [31:0] perf_preempts;
`endif

  rollback_arbiter #(
    .NUM_ROB      (32),
    .NUM_REQ      (3),
    .DRAIN_CYCLES (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .en_i             (en),
    .req_valid_i      (req_valid),
    .req_rob_idx_i    (req_rob_idx),
    .req_target_pc_i  (req_target_pc),
    .rob_head_i       (rob_head),
    .rob_count_i      (rob_count),
    .grant_o          (grant),
    .rollback_en_o    (rollback_en),
    .rollback_idx_o   (rollback_idx),
    .redirect_en_o    (redirect_en),
    .redirect_pc_o    (redirect_pc),
    .stall_dispatch_o (stall_dispatch),
    .busy_o           (busy)
`ifdef ROLLBACK_ARB_PERF_EN
    ,
    .perf_rollbacks_o (perf_rollbacks),
    .perf_preempts_o  (perf_preempts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  head;
    logic [5:0]  count;
    logic [2:0]  valid;
    logic [14:0] idx;    // {req2, req1, req0}
    logic [2:0]  grant;
  } vec_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] pc;
  } exp_t;

  vec_t  vecs [8];
  exp_t  sb_q [$];
  exp_t  mon_e;
  int    total = 0;
  int    bad   = 0;
  logic  mon_on = 1'b0;
  int    n;
`ifdef ROLLBACK_ARB_PERF_EN
  logic [31:0] rb0, pre0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Counts consecutive cycles of stall starting at the current negedge, bounded.
  task automatic count_stall(output int cnt);
    cnt = 0;
    while (stall_dispatch && cnt < 20) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  // Issues a single request from requester r with head=0,count=16; returns at the FIRE cycle.
  task automatic start_fire(input int r, input logic [4:0] idx, input logic [63:0] pc);
    exp_t e;
    @(negedge clock);
    rob_head  = 5'd0;
    rob_count = 6'd16;
    req_rob_idx[r*5 +: 5]    = idx;
    req_target_pc[r*64 +: 64] = pc;
    req_valid = 3'(1 << r);
    #1;
    chk("start_grant", 64'(grant), 64'(1 << r));
    e.idx = idx;
    e.pc  = pc;
    sb_q.push_back(e);
    @(negedge clock);
    req_valid = 3'b000;
  endtask

  always @(negedge clock) begin
    if (mon_on && rollback_en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rollback: got idx %0d want no pulse", rollback_idx);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rb_idx", 64'(rollback_idx), 64'(mon_e.idx));
        chk("rb_pc", redirect_pc, mon_e.pc);
        chk("redirect_en", 64'(redirect_en), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [191:0] pcs;

    vecs[0] = '{head: 5'd0,  count: 6'd8,  valid: 3'b001, idx: {5'd0, 5'd0, 5'd5},   grant: 3'b001};
    vecs[1] = '{head: 5'd30, count: 6'd10, valid: 3'b011, idx: {5'd0, 5'd31, 5'd2},  grant: 3'b010};
    vecs[2] = '{head: 5'd4,  count: 6'd3,  valid: 3'b010, idx: {5'd0, 5'd10, 5'd0},  grant: 3'b000};
    vecs[3] = '{head: 5'd0,  count: 6'd16, valid: 3'b111, idx: {5'd7, 5'd7, 5'd7},   grant: 3'b001};
    vecs[4] = '{head: 5'd3,  count: 6'd0,  valid: 3'b111, idx: {5'd3, 5'd4, 5'd5},   grant: 3'b000};
    vecs[5] = '{head: 5'd10, count: 6'd32, valid: 3'b110, idx: {5'd9, 5'd9, 5'd0},   grant: 3'b010};
    vecs[6] = '{head: 5'd0,  count: 6'd32, valid: 3'b110, idx: {5'd2, 5'd3, 5'd0},   grant: 3'b100};
    vecs[7] = '{head: 5'd20, count: 6'd12, valid: 3'b101, idx: {5'd0, 5'd0, 5'd31},  grant: 3'b001};

    reset = 1'b1;
    en = 1'b0;
    req_valid = '0;
    req_rob_idx = '0;
    req_target_pc = '0;
    rob_head = '0;
    rob_count = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mon_on = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_rollback", 64'(rollback_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall_dispatch), 64'd0);
    chk("rst_idx", 64'(rollback_idx), 64'd0);
    chk("rst_pc", redirect_pc, 64'd0);
`ifdef ROLLBACK_ARB_PERF_EN
    chk("rst_perf_rb", 64'(perf_rollbacks), 64'd0);
`endif
    en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      pcs = {64'h4000 + 64'(v * 16), 64'h2000 + 64'(v * 16), 64'h1000 + 64'(v * 16)};
      @(negedge clock);
      rob_head      = vecs[v].head;
      rob_count     = vecs[v].count;
      req_rob_idx   = vecs[v].idx;
      req_target_pc = pcs;
      req_valid     = vecs[v].valid;
      #1;
      chk($sformatf("vec%0d_grant", v), 64'(grant), 64'(vecs[v].grant));
      for (int w = 0; w < 3; w++) begin
        if (vecs[v].grant[w]) begin
          e.idx = vecs[v].idx[w*5 +: 5];
          e.pc  = pcs[w*64 +: 64];
          sb_q.push_back(e);
        end
      end
      @(negedge clock);
      req_valid = 3'b000;
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].grant != 3'b000));
      count_stall(n);
      chk($sformatf("vec%0d_stall_len", v), 64'(n), (vecs[v].grant != 3'b000) ? 64'd3 : 64'd0);
    end

    // Older request in first drain cycle pre-empts and restarts the window.
`ifdef ROLLBACK_ARB_PERF_EN
    rb0  = perf_rollbacks;
    pre0 = perf_preempts;
`endif
    start_fire(0, 5'd6, 64'h6000);
    @(negedge clock);
    req_rob_idx[14:10]     = 5'd3;
    req_target_pc[191:128] = 64'h3300;
    req_valid = 3'b100;
    #1;
    chk("preempt_grant", 64'(grant), 64'b100);
    e.idx = 5'd3;
    e.pc  = 64'h3300;
    sb_q.push_back(e);
    @(negedge clock);
    req_valid = 3'b000;
    count_stall(n);
    chk("preempt_stall_len", 64'(n), 64'd3);
`ifdef ROLLBACK_ARB_PERF_EN
    chk("perf_preempts", 64'(perf_preempts - pre0), 64'd1);
    chk("perf_rollbacks", 64'(perf_rollbacks - rb0), 64'd2);
`endif

    // Younger request in drain is dropped; idle on schedule.
    start_fire(0, 5'd6, 64'h6100);
    @(negedge clock);
    req_rob_idx[4:0] = 5'd9;
    req_valid = 3'b001;
    #1;
    chk("younger_grant", 64'(grant), 64'd0);
    @(negedge clock);
    req_valid = 3'b000;
    count_stall(n);
    chk("younger_stall_len", 64'(n), 64'd1);

    // Equal age is not strictly older: dropped.
    start_fire(1, 5'd6, 64'h6200);
    @(negedge clock);
    req_rob_idx[4:0] = 5'd6;
    req_valid = 3'b001;
    #1;
    chk("equal_grant", 64'(grant), 64'd0);
    @(negedge clock);
    req_valid = 3'b000;
    count_stall(n);
    chk("equal_stall_len", 64'(n), 64'd1);

    // en low freezes drain and blocks even an older request.
    start_fire(0, 5'd4, 64'h6300);
    @(negedge clock);
    en = 1'b0;
    req_rob_idx[14:10] = 5'd1;
    req_valid = 3'b100;
    #1;
    chk("frozen_grant", 64'(grant), 64'd0);
    repeat (4) @(negedge clock);
    chk("frozen_busy", 64'(busy), 64'd1);
    req_valid = 3'b000;
    en = 1'b1;
    count_stall(n);
    chk("frozen_stall_len", 64'(n), 64'd2);

    // Reset during FIRE: no further pulse, everything cleared.
    start_fire(2, 5'd5, 64'h6400);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_rollback", 64'(rollback_en), 64'd0);
    chk("midrst_stall", 64'(stall_dispatch), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_idx", 64'(rollback_idx), 64'd0);
    chk("midrst_pc", redirect_pc, 64'd0);
    repeat (3) @(negedge clock);
    chk("midrst_busy_later", 64'(busy), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rollback_arbiter.md
# rollback_arbiter

Arbitrates branch-mispredict and memory-order-violation recovery requests for the ROB and sequences the resulting rollback. Each cycle it picks the oldest valid request relative to the ROB head and issues a single-cycle rollback to the ROB together with a fetch redirect. It then holds dispatch stalled for a fixed drain window. An older request arriving during the window pre-empts the pending one; younger requests are discarded because they are already squashed.

## Interface
Parameters:
- NUM_ROB, 32, ROB entries (power of two); IW = $clog2(NUM_ROB)
- NUM_REQ, 3, recovery requesters (0,1 = branch units, 2 = LQ violation)
- DRAIN_CYCLES, 2, dispatch-stall cycles after each rollback pulse (≥1)

Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- en  in  1  global enable; low freezes all state
- req_valid  in  NUM_REQ  recovery request
- req_rob_idx  in  NUM_REQ×IW  ROB index of offending instruction
- req_target_pc  in  NUM_REQ×64  correct fetch PC
- rob_head  in  IW  current ROB head
- rob_count  in  IW+1  occupied entries (0..NUM_ROB)
- grant  out  NUM_REQ  one-hot, combinational, requester accepted this cycle
- rollback_en  out  1  one-cycle rollback pulse to ROB
- rollback_idx  out  IW  ROB index to roll back to (entries after it squashed)
- redirect_en  out  1  equals rollback_en
- redirect_pc  out  64  target PC, valid with redirect_en
- stall_dispatch  out  1  block dispatch
- busy  out  1  FSM not IDLE

## Operation
- Age of index x = (x − rob_head) mod NUM_ROB, IW-bit unsigned subtract with wrap. Request i is in range iff age < rob_count; out-of-range requests are ignored and never granted.
- Winner = in-range request with smallest age; ties go to the lowest requester number. grant is one-hot on the winner only when the winner is accepted (see below), otherwise zero.
- FSM states: IDLE, FIRE, DRAIN.
  - IDLE: on winner → latch idx/pc into pending regs, goto FIRE.
  - FIRE: rollback_en=1 for this cycle. Winner older than pending → re-latch, stay FIRE. Otherwise → DRAIN, counter=DRAIN_CYCLES−1.
  - DRAIN: winner strictly older than pending (age computed against current rob_head) → re-latch, goto FIRE. Otherwise decrement; at 0 → IDLE.
- A request with age ≥ pending age in FIRE/DRAIN is dropped (grant=0).
- stall_dispatch = (state≠IDLE). busy = same.
- rollback_idx/redirect_pc hold the pending values outside FIRE; these are don't-care when rollback_en=0.
- rollback_en and redirect_en are gated by en; with en low, no state, counter or pending register changes.

## Timing
- Request sampled at edge N → rollback_en high in cycle N+1 (registered, one cycle) → stall_dispatch high cycles N+1 .. N+1+DRAIN_CYCLES → IDLE at N+2+DRAIN_CYCLES. Zero-cycle gap: a new request in the final DRAIN cycle fires next cycle only if older.
- Reset values: state IDLE, counter 0, pending idx 0, pending pc 0; all outputs 0.
- Reset mid-FIRE/DRAIN: next cycle IDLE, outputs 0, pending cleared; no further pulse.
- Simultaneous request from all NUM_REQ with equal idx: requester 0 wins.
- rob_count=0: all requests ignored. rob_count=NUM_ROB: all indices in range.

## Configuration
- ROLLBACK_ARB_PERF_EN defined: adds outputs perf_rollbacks (32) and perf_preempts (32). These are saturating counters of FIRE entries and of pre-emptive re-latches, reset to 0 and frozen when en is low.
- ROLLBACK_ARB_PERF_EN undefined: those ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- head=0, count=8, req0 idx=5, pc=0x1000 → grant=001; next cycle rollback_en=1, idx=5, redirect_pc=0x1000; stall high 3 cycles; then IDLE.
- head=30, count=10, req0 idx=2, req1 idx=31 same cycle → grant=010, rollback_idx=31 (wrap-around age 1 beats age 4).
- After firing idx=6 (head=0), req2 idx=3 in first DRAIN cycle → second rollback_en with idx=3; stall extends a further DRAIN_CYCLES; perf_preempts=1 when the macro is defined.
- During DRAIN of idx=6, req0 idx=9 → grant=0, no pulse, IDLE on schedule.
- head=4, count=3, req1 idx=10 → ignored: grant=0, busy stays 0.
- Reset asserted in FIRE cycle → next cycle rollback_en=0, stall_dispatch=0, busy=0.
